// File: rtl/alu_issue_ctrl_if.sv
// Handshake bundle between issue front end, ALU and writeback.
// slave: the issue controller; master: the environment (decode/regfile, ALU, writeback).
interface alu_issue_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [DATA_W-1:0] in_rs1;
   logic [DATA_W-1:0] in_rs2;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [3:0]        alu_ctrl;
   logic [DATA_W-1:0] alu_c;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [4:0]        out_rd;
   logic              out_illegal;

   modport slave (
      input  in_valid, in_instr, in_rs1, in_rs2, alu_c, out_ready,
      output in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_result, out_rd, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_rs1, in_rs2, alu_c, out_ready,
      input  in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_result, out_rd, out_illegal
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// RV32I integer-op front end: decodes one instruction to ALU operands/control,
// waits one cycle for the combinational ALU, then returns the captured result.
module alu_issue_ctrl #(
   parameter int         DATA_W       = 32,
   parameter logic [3:0] ILLEGAL_CTRL = 4'd15
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_issue_ctrl_if.slave  bus
);

   localparam logic [3:0] CTRL_ADD  = 4'd0;
   localparam logic [3:0] CTRL_SUB  = 4'd1;
   localparam logic [3:0] CTRL_XOR  = 4'd2;
   localparam logic [3:0] CTRL_OR   = 4'd3;
   localparam logic [3:0] CTRL_AND  = 4'd4;
   localparam logic [3:0] CTRL_SLL  = 4'd5;
   localparam logic [3:0] CTRL_SRL  = 4'd6;
   localparam logic [3:0] CTRL_SRA  = 4'd7;
   localparam logic [3:0] CTRL_SLT  = 4'd8;
   localparam logic [3:0] CTRL_SLTU = 4'd9;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [3:0]        alu_ctrl_q, alu_ctrl_d;
   logic [4:0]        rd_q, rd_d;
   logic              illegal_q, illegal_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;

   logic [6:0]        opcode_s;
   logic [2:0]        f3_s;
   logic [6:0]        f7_s;
   logic [DATA_W-1:0] imm_s;
   logic [DATA_W-1:0] shamt_i_s;
   logic [DATA_W-1:0] shamt_r_s;
   logic [DATA_W-1:0] dec_a_s;
   logic [DATA_W-1:0] dec_b_s;
   logic [3:0]        dec_ctrl_s;
   logic              dec_illegal_s;

   assign opcode_s  = bus.in_instr[6:0];
   assign f3_s      = bus.in_instr[14:12];
   assign f7_s      = bus.in_instr[31:25];
   assign imm_s     = {{(DATA_W-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
   // The ALU does not mask shift amounts, so only the low five bits are ever passed on.
   assign shamt_i_s = {{(DATA_W-5){1'b0}}, bus.in_instr[24:20]};
   assign shamt_r_s = {{(DATA_W-5){1'b0}}, bus.in_rs2[4:0]};

   // Instruction decode to ALU operands and control code.
   always_comb begin
      dec_a_s       = bus.in_rs1;
      dec_b_s       = bus.in_rs2;
      dec_ctrl_s    = CTRL_ADD;
      dec_illegal_s = 1'b0;
      case (opcode_s)
         OP_R: begin
            case (f3_s)
               3'b000: begin
                  if (f7_s == F7_BASE) begin
                     dec_ctrl_s = CTRL_ADD;
                  end else if (f7_s == F7_ALT) begin
                     dec_ctrl_s = CTRL_SUB;
                  end else begin
                     dec_illegal_s = 1'b1;
                  end
               end
               3'b001: begin
                  dec_ctrl_s    = CTRL_SLL;
                  dec_b_s       = shamt_r_s;
                  dec_illegal_s = (f7_s != F7_BASE);
               end
               3'b010: begin
                  dec_ctrl_s    = CTRL_SLT;
                  dec_illegal_s = (f7_s != F7_BASE);
               end
               3'b011: begin
                  dec_ctrl_s    = CTRL_SLTU;
                  dec_illegal_s = (f7_s != F7_BASE);
               end
               3'b100: begin
                  dec_ctrl_s    = CTRL_XOR;
                  dec_illegal_s = (f7_s != F7_BASE);
               end
               3'b101: begin
                  dec_b_s = shamt_r_s;
                  if (f7_s == F7_BASE) begin
                     dec_ctrl_s = CTRL_SRL;
                  end else if (f7_s == F7_ALT) begin
                     dec_ctrl_s = CTRL_SRA;
                  end else begin
                     dec_illegal_s = 1'b1;
                  end
               end
               3'b110: begin
                  dec_ctrl_s    = CTRL_OR;
                  dec_illegal_s = (f7_s != F7_BASE);
               end
               3'b111: begin
                  dec_ctrl_s    = CTRL_AND;
                  dec_illegal_s = (f7_s != F7_BASE);
               end
               default: begin
                  dec_illegal_s = 1'b1;
               end
            endcase
         end
         OP_I: begin
            dec_b_s = imm_s;
            case (f3_s)
               3'b000: dec_ctrl_s = CTRL_ADD;
               3'b010: dec_ctrl_s = CTRL_SLT;
               3'b011: dec_ctrl_s = CTRL_SLTU;
               3'b100: dec_ctrl_s = CTRL_XOR;
               3'b110: dec_ctrl_s = CTRL_OR;
               3'b111: dec_ctrl_s = CTRL_AND;
               3'b001: begin
                  dec_ctrl_s    = CTRL_SLL;
                  dec_b_s       = shamt_i_s;
                  dec_illegal_s = (f7_s != F7_BASE);
               end
               3'b101: begin
                  dec_b_s = shamt_i_s;
                  if (f7_s == F7_BASE) begin
                     dec_ctrl_s = CTRL_SRL;
                  end else if (f7_s == F7_ALT) begin
                     dec_ctrl_s = CTRL_SRA;
                  end else begin
                     dec_illegal_s = 1'b1;
                  end
               end
               default: begin
                  dec_illegal_s = 1'b1;
               end
            endcase
         end
         default: begin
            dec_illegal_s = 1'b1;
         end
      endcase
      // Illegal ops present zero operands so the ALU result is harmless.
      if (dec_illegal_s) begin
         dec_a_s    = {DATA_W{1'b0}};
         dec_b_s    = {DATA_W{1'b0}};
         dec_ctrl_s = ILLEGAL_CTRL;
      end else begin
         dec_a_s    = dec_a_s;
      end
   end

   // Next-state and registered-output logic for the IDLE/EXEC/DONE sequence.
   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_ctrl_d  = alu_ctrl_q;
      rd_d        = rd_q;
      illegal_d   = illegal_q;
      result_d    = result_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_d    = ST_EXEC;
               alu_a_d    = dec_a_s;
               alu_b_d    = dec_b_s;
               alu_ctrl_d = dec_ctrl_s;
               rd_d       = bus.in_instr[11:7];
               illegal_d  = dec_illegal_s;
               in_ready_d = 1'b0;
            end else begin
               in_ready_d = 1'b1;
            end
         end
         ST_EXEC: begin
            state_d     = ST_DONE;
            result_d    = illegal_q ? {DATA_W{1'b0}} : bus.alu_c;
            out_valid_d = 1'b1;
         end
         ST_DONE: begin
            // A new in_valid here is left waiting; it is taken in IDLE next cycle.
            if (bus.out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         alu_a_q     <= {DATA_W{1'b0}};
         alu_b_q     <= {DATA_W{1'b0}};
         alu_ctrl_q  <= 4'd0;
         rd_q        <= 5'd0;
         illegal_q   <= 1'b0;
         result_q    <= {DATA_W{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_ctrl_q  <= alu_ctrl_d;
         rd_q        <= rd_d;
         illegal_q   <= illegal_d;
         result_q    <= result_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.alu_ctrl    = alu_ctrl_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_result  = result_q;
   assign bus.out_rd      = rd_q;
   assign bus.out_illegal = illegal_q;

endmodule
